grid_turn_ctrl: RTL
===================

// Module: grid_turn_ctrl
// PURPOSE
//  Parametrised successor of the 4x4 cursor/select board controller. Holds a ROWS x COLS board,
//  a wrap-around cursor stepped by a button, and placement of the current player's mark on select.
//  Adds N players, bidirectional cursor, occupied-cell rejection, per-turn timeout and board-full end.
//  Sits between the debounced push-buttons and the board renderer / score logic.
// PARAMETERS
//  ROWS        4    board rows
//  COLS        4    board columns; CELLS = ROWS*COLS, CUR_W = max(1,$clog2(CELLS))
//  NUM_PLAYERS 2    players, 2..2**CELL_W-1; PLY_W = max(1,$clog2(NUM_PLAYERS))
//  CELL_W      4    bits per cell; 0 = empty, p+1 = mark of player p
//  TIMER_W     8    turn-timer width
//  TURN_CYCLES 200  clocks per turn before forced pass; 0 disables timer; must be <= 2**TIMER_W
// PORTS
//  clk       in   1              system clock, all logic on rising edge
//  rst       in   1              reset, synchronous, active-low
//  move      in   1              cursor button, level; acts on rising edge only
//  move_dir  in   1              0: cursor+1, 1: cursor-1 (sampled on the move edge)
//  select    in   1              select button, level; acts on rising edge only
//  board     out  CELLS*CELL_W   cell i at [i*CELL_W +: CELL_W], i = row*COLS+col
//  cursor    out  CUR_W          current cell index
//  player    out  PLY_W          player whose turn it is
//  timer     out  TIMER_W        remaining clocks in turn
//  placed    out  CUR_W+1        number of occupied cells
//  state     out  2              FSM state code (package enum)
//  reject    out  1              1-cycle pulse: select on occupied cell
//  timeout   out  1              1-cycle pulse: turn forfeited by timer
//  done      out  1              high while board full (state DONE)
// BEHAVIOUR
//  - Reset (rst=0 at a clk edge): board=0, cursor=0, player=0, placed=0, timer=0, state=IDLE,
//    reject=timeout=done=0, edge-detector history=0. Reset wins over every other event, any state.
//  - Edge: mv_e = move & ~move_q, sel_e = select & ~select_q; history regs update every cycle.
//    Holding a button yields exactly one event. Same-cycle sel_e and mv_e: select wins, move dropped.
//  - IDLE: mv_e ignored; sel_e -> PLAY, timer <= TURN_CYCLES-1, no placement.
//  - PLAY, sel_e, cell[cursor]==0: cell <= player+1, placed+1, player <= (player+1) mod NUM_PLAYERS,
//    timer reload; if placed+1==CELLS -> DONE (done=1 next cycle). All effects on the same edge.
//  - PLAY, sel_e, cell occupied: reject=1 for that one cycle; board/player/timer unchanged.
//  - PLAY, mv_e: cursor +/-1 with wrap (CELLS-1 -> 0 fwd, 0 -> CELLS-1 back); latency 1 clock.
//  - PLAY timer (TURN_CYCLES>0): decrements each cycle w/o placement; timer==0 and no sel_e ->
//    timeout=1, player advances, timer reload. sel_e at timer==0 -> placement/reject, no timeout.
//  - DONE: mv_e ignored, cursor/board frozen; sel_e -> CLEAR.
//  - CLEAR (1 cycle): board=0, placed=0, cursor=0, player=0, timer=0, done=0 -> IDLE.
//  - reject/timeout never high simultaneously; both 0 outside PLAY.
//  - Cursor wraps via explicit compare, never relying on power-of-2 CELLS.
// STRUCTURE
//  - grid_pkg: typedef enum logic [1:0] {IDLE, PLAY, DONE, CLEAR} grid_state_t;
//    localparam CELL_EMPTY = '0; width helper functions for CUR_W / PLY_W.
//  - Sub-module btn_edge (1-bit registered rising-edge detector, sync active-low rst),
//    instantiated for move and select.
//  - Top: one FSM always_ff, board as CELLS x CELL_W array flattened onto board port.
//  - Parameter checks in an initial block: NUM_PLAYERS+1 <= 2**CELL_W, TURN_CYCLES <= 2**TIMER_W.
// TESTING  (ROWS=COLS=4, NUM_PLAYERS=2, CELL_W=4, TURN_CYCLES=20)
//  1 rst=0 two clks after random activity -> board=0, cursor=0, player=0, state=IDLE, all pulses 0.
//  2 select pulse -> PLAY, timer=19; 2nd select -> cell0=1, player=1, placed=1; cursor+1 -> select
//    -> cell1=2, player=0.
//  3 move held 5 clks -> cursor +1 only; 16 fwd pulses from 0 -> 0; move_dir=1 at 0 -> 15;
//    move+select same clk -> placement at old cursor, cursor unchanged.
//  4 select on occupied cell0 -> reject=1 for 1 clk, board, player, placed unchanged.
//  5 no input 20 clks in PLAY -> timeout=1 once, player 0->1, timer=19; select at timer==0 -> no
//    timeout.
//  6 fill all 16 cells -> done=1, state=DONE, move ignored; select -> CLEAR then IDLE, board=0;
//    rst=0 mid-PLAY -> full reset values next clk.

Source files
------------

// File: rtl/grid_turn_ctrl_pkg.sv
// Shared state encoding, cell constants and width helpers for the grid turn controller.
package grid_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DONE  = 2'd2,
        CLEAR = 2'd3
    } grid_state_t;

    localparam int unsigned CELL_EMPTY = 0;

    function automatic int cur_width(input int cells);
        return (cells > 1) ? $clog2(cells) : 1;
    endfunction

    function automatic int ply_width(input int num_players);
        return (num_players > 1) ? $clog2(num_players) : 1;
    endfunction

endpackage

// File: rtl/grid_turn_ctrl_if.sv
// Button inputs and board/turn status outputs of the grid turn controller.
interface grid_turn_ctrl_if #(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int NUM_PLAYERS = 2,
    parameter int CELL_W      = 4,
    parameter int TIMER_W     = 8
);
    import grid_pkg::*;

    localparam int CELLS = ROWS * COLS;
    localparam int CUR_W = cur_width(CELLS);
    localparam int PLY_W = ply_width(NUM_PLAYERS);

    logic                      move;
    logic                      move_dir;
    logic                      select;
    logic [CELLS*CELL_W-1:0]   board;
    logic [CUR_W-1:0]          cursor;
    logic [PLY_W-1:0]          player;
    logic [TIMER_W-1:0]        timer;
    logic [CUR_W:0]            placed;
    grid_state_t               state;
    logic                      reject;
    logic                      timeout;
    logic                      done;

    modport master (
        output move, move_dir, select,
        input  board, cursor, player, timer, placed, state, reject, timeout, done
    );

    modport slave (
        input  move, move_dir, select,
        output board, cursor, player, timer, placed, state, reject, timeout, done
    );

endinterface

// File: rtl/grid_turn_ctrl_btn_edge.sv
// Registered rising-edge detector for a level push-button; one pulse per press.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (!rst) level_q <= 1'b0;
        else      level_q <= level;
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/grid_turn_ctrl.sv
// Turn-based board controller: wrap-around cursor, mark placement, turn timer and board-full end.
module grid_turn_ctrl
    import grid_pkg::*;
#(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int NUM_PLAYERS = 2,
    parameter int CELL_W      = 4,
    parameter int TIMER_W     = 8,
    parameter int TURN_CYCLES = 200
) (
    input logic             clk,
    input logic             rst,
    grid_turn_ctrl_if.slave bus
);

    localparam int CELLS = ROWS * COLS;
    localparam int CUR_W = cur_width(CELLS);
    localparam int PLY_W = ply_width(NUM_PLAYERS);
    localparam logic [TIMER_W-1:0] RELOAD = (TURN_CYCLES > 0) ? TIMER_W'(TURN_CYCLES - 1) : '0;
    localparam logic [CUR_W-1:0]   LAST_CELL   = CUR_W'(CELLS - 1);
    localparam logic [PLY_W-1:0]   LAST_PLAYER = PLY_W'(NUM_PLAYERS - 1);
    localparam logic [CUR_W:0]     FULL        = (CUR_W + 1)'(CELLS);
    localparam logic [CELL_W-1:0]  EMPTY       = CELL_W'(CELL_EMPTY);

    if (NUM_PLAYERS + 1 > 2 ** CELL_W) begin : g_bad_players
        $error("grid_turn_ctrl: NUM_PLAYERS marks do not fit in CELL_W bits");
    end
    if (TURN_CYCLES > 2 ** TIMER_W) begin : g_bad_timer
        $error("grid_turn_ctrl: TURN_CYCLES exceeds TIMER_W range");
    end

    grid_state_t              state_q, state_d;
    logic [CELL_W-1:0]        cells_q [CELLS];
    logic [CELL_W-1:0]        cells_d [CELLS];
    logic [CUR_W-1:0]         cursor_q, cursor_d;
    logic [PLY_W-1:0]         player_q, player_d, next_player;
    logic [TIMER_W-1:0]       timer_q, timer_d;
    logic [CUR_W:0]           placed_q, placed_d;
    logic                     reject_q, reject_d;
    logic                     timeout_q, timeout_d;
    logic                     wipe;
    logic                     mv_e, sel_e;

    btn_edge u_move_edge   (.clk(clk), .rst(rst), .level(bus.move),   .rise(mv_e));
    btn_edge u_select_edge (.clk(clk), .rst(rst), .level(bus.select), .rise(sel_e));

    assign next_player = (player_q == LAST_PLAYER) ? '0 : player_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cells_q   <= '{default: EMPTY};
            cursor_q  <= '0;
            player_q  <= '0;
            timer_q   <= '0;
            placed_q  <= '0;
            reject_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cells_q   <= cells_d;
            cursor_q  <= cursor_d;
            player_q  <= player_d;
            timer_q   <= timer_d;
            placed_q  <= placed_d;
            reject_q  <= reject_d;
            timeout_q <= timeout_d;
        end
    end

    // Select takes priority over move; the turn timer only runs on cycles without a select edge.
    always_comb begin
        state_d   = state_q;
        cells_d   = cells_q;
        cursor_d  = cursor_q;
        player_d  = player_q;
        timer_d   = timer_q;
        placed_d  = placed_q;
        reject_d  = 1'b0;
        timeout_d = 1'b0;
        wipe      = 1'b0;
        case (state_q)
            IDLE: begin
                if (sel_e) begin
                    state_d = PLAY;
                    timer_d = RELOAD;
                end
            end
            PLAY: begin
                if (sel_e) begin
                    if (cells_q[cursor_q] == EMPTY) begin
                        cells_d[cursor_q] = CELL_W'(player_q) + 1'b1;
                        placed_d          = placed_q + 1'b1;
                        player_d          = next_player;
                        timer_d           = RELOAD;
                        if (placed_q + 1'b1 == FULL) state_d = DONE;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else begin
                    if (mv_e) begin
                        if (bus.move_dir)
                            cursor_d = (cursor_q == '0) ? LAST_CELL : cursor_q - 1'b1;
                        else
                            cursor_d = (cursor_q == LAST_CELL) ? '0 : cursor_q + 1'b1;
                    end
                    if (TURN_CYCLES > 0) begin
                        if (timer_q == '0) begin
                            timeout_d = 1'b1;
                            player_d  = next_player;
                            timer_d   = RELOAD;
                        end else begin
                            timer_d = timer_q - 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                if (sel_e) begin
                    state_d = CLEAR;
                    wipe    = 1'b1;
                end
            end
            CLEAR: begin
                state_d = IDLE;
                wipe    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (wipe) begin
            cells_d  = '{default: EMPTY};
            cursor_d = '0;
            player_d = '0;
            timer_d  = '0;
            placed_d = '0;
        end
    end

    for (genvar i = 0; i < CELLS; i++) begin : g_board
        assign bus.board[i*CELL_W +: CELL_W] = cells_q[i];
    end

    assign bus.cursor  = cursor_q;
    assign bus.player  = player_q;
    assign bus.timer   = timer_q;
    assign bus.placed  = placed_q;
    assign bus.state   = state_q;
    assign bus.reject  = reject_q;
    assign bus.timeout = timeout_q;
    assign bus.done    = (state_q == DONE);

endmodule
